// File: rtl/datapath_ctrl.sv
// datapath_ctrl: sequencing controller for the 4-bit datapath (input mux,
// register file, A/B demux, operand registers, ULA).
//
// Takes one instruction per instr_valid/instr_ready handshake and drives the
// datapath control lines until that instruction completes. Every output is
// registered except instr_ready, which is high only in IDLE.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   instr_valid  instruction word on instr is valid
//   instr_ready  controller can accept an instruction (IDLE only)
//   instr        {class, op, dst, srcA, srcB, imm, cin}
//   Cout         carry out from the ULA
//   dados        immediate to the datapath input mux
//   addr         register-file address
//   sel21        0 = dados, 1 = ULA result into the register file
//   sel12        0 = RF read to reg A, 1 = to reg B
//   escrita      register-file write enable
//   Cin          ULA carry in
//   operacao     ULA operation
//   done         one-cycle pulse on the final cycle of an instruction
//   carry_flag   Cout captured when an ALU writeback finishes
//
// Optional feature (macro CTRL_CARRY_CHAIN_EN): when defined, an ALU
// instruction with cin=1 takes Cin from carry_flag for multi-word add
// chaining. When undefined, Cin is the instruction's cin bit.
module datapath_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter int OP_W   = 3,
    localparam int INSTR_W = 2 + OP_W + 3*ADDR_W + DATA_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               Cout,
    output logic [DATA_W-1:0]  dados,
    output logic [ADDR_W-1:0]  addr,
    output logic               sel21,
    output logic               sel12,
    output logic               escrita,
    output logic               Cin,
    output logic [OP_W-1:0]    operacao,
    output logic               done,
    output logic               carry_flag
);

    localparam int CLS_LSB = INSTR_W - 2;
    localparam int OP_LSB  = CLS_LSB - OP_W;
    localparam int DST_LSB = OP_LSB - ADDR_W;
    localparam int SA_LSB  = DST_LSB - ADDR_W;
    localparam int SB_LSB  = SA_LSB - ADDR_W;
    localparam int IMM_LSB = 1;

    localparam logic [1:0] CLS_NOP  = 2'b00;
    localparam logic [1:0] CLS_LOAD = 2'b01;
    localparam logic [1:0] CLS_ALU  = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_NOP, S_LOAD, S_RD_A, S_RD_B, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t state, state_nxt;

    // Only the fields needed after the accept cycle are kept.
    logic [ADDR_W-1:0] dst_q, sb_q;

    logic [1:0]        cls_in;
    logic [OP_W-1:0]   op_in;
    logic [ADDR_W-1:0] dst_in, sa_in, sb_in;
    logic [DATA_W-1:0] imm_in;
    logic              cin_in, cin_sel;

    logic [DATA_W-1:0] dados_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [OP_W-1:0]   op_nxt;
    logic              cin_nxt, sel21_nxt, sel12_nxt, esc_nxt, done_nxt;

    assign cls_in = instr[CLS_LSB +: 2];
    assign op_in  = instr[OP_LSB  +: OP_W];
    assign dst_in = instr[DST_LSB +: ADDR_W];
    assign sa_in  = instr[SA_LSB  +: ADDR_W];
    assign sb_in  = instr[SB_LSB  +: ADDR_W];
    assign imm_in = instr[IMM_LSB +: DATA_W];
    assign cin_in = instr[0];

`ifdef CTRL_CARRY_CHAIN_EN
    assign cin_sel = cin_in & carry_flag;
`else
    assign cin_sel = cin_in;
`endif

    assign instr_ready = (state == S_IDLE);

    // Outputs are registered from the state being entered, so each state's
    // control values are visible during the cycle the FSM sits in it.
    always_comb begin
        state_nxt = state;
        dados_nxt = dados;
        addr_nxt  = addr;
        op_nxt    = operacao;
        cin_nxt   = Cin;
        sel21_nxt = 1'b0;
        sel12_nxt = 1'b0;
        esc_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    case (cls_in)
                        CLS_NOP: begin
                            state_nxt = S_NOP;
                            done_nxt  = 1'b1;
                        end
                        CLS_LOAD: begin
                            state_nxt = S_LOAD;
                            addr_nxt  = dst_in;
                            dados_nxt = imm_in;
                            esc_nxt   = 1'b1;
                            done_nxt  = 1'b1;
                        end
                        CLS_ALU: begin
                            state_nxt = S_RD_A;
                            addr_nxt  = sa_in;
                            op_nxt    = op_in;
                            cin_nxt   = cin_sel;
                        end
                        default: state_nxt = S_HALT;
                    endcase
                end
            end
            S_NOP, S_LOAD: state_nxt = S_IDLE;
            S_RD_A: begin
                state_nxt = S_RD_B;
                addr_nxt  = sb_q;
                sel12_nxt = 1'b1;
            end
            S_RD_B: begin
                state_nxt = S_EXEC;
                sel21_nxt = 1'b1;
            end
            S_EXEC: begin
                state_nxt = S_WB;
                addr_nxt  = dst_q;
                sel21_nxt = 1'b1;
                esc_nxt   = 1'b1;
                done_nxt  = 1'b1;
            end
            S_WB:    state_nxt = S_IDLE;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dados    <= '0;
            addr     <= '0;
            operacao <= '0;
            Cin      <= 1'b0;
            sel21    <= 1'b0;
            sel12    <= 1'b0;
            escrita  <= 1'b0;
            done     <= 1'b0;
        end else begin
            dados    <= dados_nxt;
            addr     <= addr_nxt;
            operacao <= op_nxt;
            Cin      <= cin_nxt;
            sel21    <= sel21_nxt;
            sel12    <= sel12_nxt;
            escrita  <= esc_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_q <= '0;
            sb_q  <= '0;
        end else if (state == S_IDLE && instr_valid) begin
            dst_q <= dst_in;
            sb_q  <= sb_in;
        end
    end

    // Carry is sampled on the edge that leaves WB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             carry_flag <= 1'b0;
        else if (state == S_WB) carry_flag <= Cout;
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        Cout = 1'b0;
    logic [3:0]  dados;
    logic [1:0]  addr;
    logic        sel21, sel12, escrita, Cin, done, carry_flag;
    logic [2:0]  operacao;

    int total = 0;
    int bad   = 0;

    datapath_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .Cout(Cout),
        .dados(dados), .addr(addr), .sel21(sel21), .sel12(sel12),
        .escrita(escrita), .Cin(Cin), .operacao(operacao), .done(done),
        .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [1:0] cls, input logic [2:0] op,
                                       input logic [1:0] d, input logic [1:0] a,
                                       input logic [1:0] b, input logic [3:0] imm,
                                       input logic cin);
        return {cls, op, d, a, b, imm, cin};
    endfunction

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++;
        if ({escrita, done, sel21, sel12, Cin, carry_flag} !== 6'b0 ||
            dados !== 4'h0 || addr !== 2'd0 || operacao !== 3'd0 || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: esc=%b done=%b s21=%b s12=%b cin=%b cf=%b dados=%h addr=%0d op=%0d rdy=%b, need all 0, rdy=1",
                     escrita, done, sel21, sel12, Cin, carry_flag, dados, addr, operacao, instr_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        instr = mk(2'b01, 3'd0, 2'd2, 2'd0, 2'd0, 4'hA, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        total++;
        if (addr !== 2'd2 || dados !== 4'hA || sel21 !== 1'b0 || escrita !== 1'b1 ||
            done !== 1'b1 || instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_cycle: addr=%0d dados=%h s21=%b esc=%b done=%b rdy=%b, need 2 A 0 1 1 0",
                     addr, dados, sel21, escrita, done, instr_ready);
        end
        tick();
        total++;
        if (escrita !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 ||
            addr !== 2'd2 || dados !== 4'hA) begin
            bad++;
            $display("FAIL load_after: esc=%b done=%b rdy=%b addr=%0d dados=%h, need 0 0 1 2 A",
                     escrita, done, instr_ready, addr, dados);
        end
    endtask

    task automatic test_alu();
        instr = mk(2'b10, 3'd3, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        total++;
        if (addr !== 2'd1 || sel12 !== 1'b0 || sel21 !== 1'b0 || escrita !== 1'b0 ||
            operacao !== 3'd3 || done !== 1'b0 || instr_ready !== 1'b0) begin
            bad++;
            $display("FAIL alu_rd_a: addr=%0d s12=%b s21=%b esc=%b op=%0d done=%b rdy=%b, need 1 0 0 0 3 0 0",
                     addr, sel12, sel21, escrita, operacao, done, instr_ready);
        end
        tick();
        total++;
        if (addr !== 2'd2 || sel12 !== 1'b1 || escrita !== 1'b0 || operacao !== 3'd3) begin
            bad++;
            $display("FAIL alu_rd_b: addr=%0d s12=%b esc=%b op=%0d, need 2 1 0 3",
                     addr, sel12, escrita, operacao);
        end
        tick();
        total++;
        if (sel21 !== 1'b1 || sel12 !== 1'b0 || escrita !== 1'b0 || done !== 1'b0 || operacao !== 3'd3) begin
            bad++;
            $display("FAIL alu_exec: s21=%b s12=%b esc=%b done=%b op=%0d, need 1 0 0 0 3",
                     sel21, sel12, escrita, done, operacao);
        end
        tick();
        total++;
        if (addr !== 2'd3 || sel21 !== 1'b1 || escrita !== 1'b1 || done !== 1'b1 || operacao !== 3'd3) begin
            bad++;
            $display("FAIL alu_wb: addr=%0d s21=%b esc=%b done=%b op=%0d, need 3 1 1 1 3",
                     addr, sel21, escrita, done, operacao);
        end
        tick();
        total++;
        if (instr_ready !== 1'b1 || escrita !== 1'b0 || done !== 1'b0 || sel21 !== 1'b0 ||
            operacao !== 3'd3 || addr !== 2'd3) begin
            bad++;
            $display("FAIL alu_idle: rdy=%b esc=%b done=%b s21=%b op=%0d addr=%0d, need 1 0 0 0 3 3",
                     instr_ready, escrita, done, sel21, operacao, addr);
        end
    endtask

    // run one ALU instruction from accept to the first IDLE cycle; returns Cin seen in RD_A
    task automatic run_alu(input logic cin_bit, input logic cout_val, output logic cin_seen,
                           output logic cf_in_wb);
        instr = mk(2'b10, 3'd1, 2'd0, 2'd1, 2'd2, 4'h0, cin_bit);
        instr_valid = 1'b1;
        Cout = cout_val;
        tick();
        instr_valid = 1'b0;
        cin_seen = Cin;
        tick(); tick(); tick();
        cf_in_wb = carry_flag;
        tick();
        Cout = 1'b0;
    endtask

    task automatic test_carry();
        logic cs, cw, exp2;
        run_alu(1'b0, 1'b1, cs, cw);
        total++;
        if (cw !== 1'b0) begin
            bad++;
            $display("FAIL carry_hold_in_wb: carry_flag=%b, need 0", cw);
        end
        total++;
        if (carry_flag !== 1'b1) begin
            bad++;
            $display("FAIL carry_capture1: carry_flag=%b, need 1", carry_flag);
        end
        run_alu(1'b1, 1'b0, cs, cw);
        total++;
        if (cs !== 1'b1) begin
            bad++;
            $display("FAIL cin_after_cout1: Cin=%b, need 1", cs);
        end
        total++;
        if (carry_flag !== 1'b0) begin
            bad++;
            $display("FAIL carry_capture0: carry_flag=%b, need 0", carry_flag);
        end
`ifdef CTRL_CARRY_CHAIN_EN
        exp2 = 1'b0;
`else
        exp2 = 1'b1;
`endif
        run_alu(1'b1, 1'b0, cs, cw);
        total++;
        if (cs !== exp2) begin
            bad++;
            $display("FAIL cin_after_cout0: Cin=%b, need %b", cs, exp2);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] imms [3];
        int dones;
        imms[0] = 4'h3; imms[1] = 4'h7; imms[2] = 4'hC;
        dones = 0;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = mk(2'b01, 3'd0, 2'(k), 2'd0, 2'd0, imms[k], 1'b0);
            tick();
            if (done === 1'b1) dones++;
            total++;
            if (done !== 1'b1 || escrita !== 1'b1 || instr_ready !== 1'b0 ||
                dados !== imms[k] || addr !== 2'(k)) begin
                bad++;
                $display("FAIL b2b_load%0d: done=%b esc=%b rdy=%b dados=%h addr=%0d, need 1 1 0 %h %0d",
                         k, done, escrita, instr_ready, dados, addr, imms[k], k);
            end
            if (k == 2) instr_valid = 1'b0;
            tick();
            total++;
            if (done !== 1'b0 || escrita !== 1'b0 || instr_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_gap%0d: done=%b esc=%b rdy=%b, need 0 0 1",
                         k, done, escrita, instr_ready);
            end
        end
        total++;
        if (dones !== 3) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d, need 3", dones);
        end
    endtask

    task automatic test_halt();
        int esc_seen;
        esc_seen = 0;
        instr = mk(2'b11, 3'd0, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr = mk(2'b01, 3'd0, 2'd1, 2'd0, 2'd0, 4'h5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (escrita !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) esc_seen++;
        end
        total++;
        if (esc_seen !== 0) begin
            bad++;
            $display("FAIL halt_absorb: %0d cycles with esc/done/rdy active, need 0", esc_seen);
        end
        instr_valid = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL halt_reset_release: rdy=%b, need 1", instr_ready);
        end
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        total++;
        if (escrita !== 1'b1 || dados !== 4'h5 || addr !== 2'd1) begin
            bad++;
            $display("FAIL halt_then_load: esc=%b dados=%h addr=%0d, need 1 5 1", escrita, dados, addr);
        end
        tick();
    endtask

    task automatic test_reset_mid_wb();
        instr = mk(2'b10, 3'd2, 2'd3, 2'd0, 2'd1, 4'h0, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick(); tick(); tick();
        total++;
        if (escrita !== 1'b1) begin
            bad++;
            $display("FAIL mid_wb_setup: esc=%b, need 1", escrita);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (escrita !== 1'b0 || done !== 1'b0 || sel21 !== 1'b0) begin
            bad++;
            $display("FAIL mid_wb_abort: esc=%b done=%b s21=%b, need 0 0 0", escrita, done, sel21);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (instr_ready !== 1'b1 || escrita !== 1'b0) begin
            bad++;
            $display("FAIL mid_wb_release: rdy=%b esc=%b, need 1 0", instr_ready, escrita);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_carry();
        test_back_to_back();
        test_halt();
        test_reset_mid_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
